// File: rtl/datapath_src_mux_if.sv
// Operand/destination select bus between the controller, GRF, ALU and DM.
// The master drives the select codes and candidates; the slave returns the selected values.
interface datapath_src_mux_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] A2;
    logic [REG_AW-1:0] A3;
    logic [1:0]        RegDst;
    logic [DATA_W-1:0] Rd2;
    logic [DATA_W-1:0] Ext;
    logic              ALUSrc;
    logic [DATA_W-1:0] C;
    logic [DATA_W-1:0] Dout;
    logic [DATA_W-1:0] PC;
    logic [1:0]        DataSrc;
    logic [REG_AW-1:0] RegDstOut;
    logic [DATA_W-1:0] ALUSrcOut;
    logic [DATA_W-1:0] DataSrcOut;
    logic              SelErr;

    modport master (
        output A2, A3, RegDst, Rd2, Ext, ALUSrc,
        output C, Dout, PC, DataSrc,
        input  RegDstOut, ALUSrcOut, DataSrcOut, SelErr
    );

    modport slave (
        input  A2, A3, RegDst, Rd2, Ext, ALUSrc,
        input  C, Dout, PC, DataSrc,
        output RegDstOut, ALUSrcOut, DataSrcOut, SelErr
    );
endinterface

// File: rtl/datapath_src_mux.sv
// GRF write-address, ALU B and GRF write-data selection with a sticky illegal-select flag.
// Define SRC_MUX_OUTREG_EN to register the three mux outputs (1-cycle latency).
module datapath_src_mux #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int LINK_REG    = 31,
    parameter int LINK_OFFSET = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    datapath_src_mux_if.slave        bus
);
    logic [REG_AW-1:0] reg_dst_sel;
    logic [DATA_W-1:0] alu_src_sel;
    logic [DATA_W-1:0] data_src_sel;
    logic [DATA_W-1:0] link_addr;
    logic              sel_err;

    // Link address wraps modulo 2^DATA_W.
    assign link_addr = bus.PC + DATA_W'(LINK_OFFSET);

    // Select code 11 and unknown codes both map to zero.
    always_comb begin
        reg_dst_sel = '0;
        case (bus.RegDst)
            2'b00:   reg_dst_sel = bus.A2;
            2'b01:   reg_dst_sel = bus.A3;
            2'b10:   reg_dst_sel = REG_AW'(LINK_REG);
            default: reg_dst_sel = '0;
        endcase
    end

    // ALU operand B: register value or extended immediate.
    always_comb begin
        alu_src_sel = '0;
        case (bus.ALUSrc)
            1'b0:    alu_src_sel = bus.Rd2;
            1'b1:    alu_src_sel = bus.Ext;
            default: alu_src_sel = '0;
        endcase
    end

    // GRF write data: ALU result, load data or link address.
    always_comb begin
        data_src_sel = '0;
        case (bus.DataSrc)
            2'b00:   data_src_sel = bus.C;
            2'b01:   data_src_sel = bus.Dout;
            2'b10:   data_src_sel = link_addr;
            default: data_src_sel = '0;
        endcase
    end

    // Sticky error; reset wins over an illegal code on the same edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sel_err <= 1'b0;
        end else if (bus.RegDst == 2'b11 || bus.DataSrc == 2'b11) begin
            sel_err <= 1'b1;
        end
    end

    assign bus.SelErr = sel_err;

`ifdef SRC_MUX_OUTREG_EN
    logic [REG_AW-1:0] reg_dst_q;
    logic [DATA_W-1:0] alu_src_q;
    logic [DATA_W-1:0] data_src_q;

    // Output stage: one cycle of latency, cleared by reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            reg_dst_q  <= '0;
            alu_src_q  <= '0;
            data_src_q <= '0;
        end else begin
            reg_dst_q  <= reg_dst_sel;
            alu_src_q  <= alu_src_sel;
            data_src_q <= data_src_sel;
        end
    end

    assign bus.RegDstOut  = reg_dst_q;
    assign bus.ALUSrcOut  = alu_src_q;
    assign bus.DataSrcOut = data_src_q;
`else
    assign bus.RegDstOut  = reg_dst_sel;
    assign bus.ALUSrcOut  = alu_src_sel;
    assign bus.DataSrcOut = data_src_sel;
`endif

endmodule

// File: tb/tb_datapath_src_mux.sv
// Directed bench for datapath_src_mux.
// Works in both the combinational and the SRC_MUX_OUTREG_EN build.
module tb_datapath_src_mux;
    logic Clk;
    logic Reset;
    int   n_cmp;
    int   n_err;

    datapath_src_mux_if #(.DATA_W(32), .REG_AW(5)) bus ();

    datapath_src_mux #(
        .DATA_W(32),
        .REG_AW(5),
        .LINK_REG(31),
        .LINK_OFFSET(4)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Let a new input pattern reach the outputs.
    task automatic settle();
`ifdef SRC_MUX_OUTREG_EN
        @(posedge Clk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic edge1();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        Reset       = 1'b1;
        bus.A2      = '0;
        bus.A3      = '0;
        bus.RegDst  = 2'b00;
        bus.Rd2     = '0;
        bus.Ext     = '0;
        bus.ALUSrc  = 1'b0;
        bus.C       = '0;
        bus.Dout    = '0;
        bus.PC      = '0;
        bus.DataSrc = 2'b00;
        edge1();
        edge1();
        check("rst_selerr", 32'(bus.SelErr), 32'h0);
        check("rst_regdst", 32'(bus.RegDstOut), 32'h0);
        check("rst_datasrc", bus.DataSrcOut, 32'h0);
        Reset = 1'b0;

        bus.A2 = 5'd8;
        bus.A3 = 5'd9;
        bus.RegDst = 2'b00; settle();
        check("regdst_00", 32'(bus.RegDstOut), 32'd8);
        bus.RegDst = 2'b01; settle();
        check("regdst_01", 32'(bus.RegDstOut), 32'd9);
        bus.RegDst = 2'b10; settle();
        check("regdst_10", 32'(bus.RegDstOut), 32'd31);
        check("selerr_legal", 32'(bus.SelErr), 32'h0);
        bus.RegDst = 2'b11; settle();
        check("regdst_11", 32'(bus.RegDstOut), 32'd0);
        edge1();
        check("selerr_regdst11", 32'(bus.SelErr), 32'h1);
        bus.RegDst = 2'b00;
        Reset = 1'b1;
        edge1();
        Reset = 1'b0;
        check("selerr_clr1", 32'(bus.SelErr), 32'h0);

        bus.Rd2 = 32'h12345678;
        bus.Ext = 32'hFFFF8000;
        bus.ALUSrc = 1'b0; settle();
        check("alusrc_0", bus.ALUSrcOut, 32'h12345678);
        bus.ALUSrc = 1'b1; settle();
        check("alusrc_1", bus.ALUSrcOut, 32'hFFFF8000);

        bus.C    = 32'h00000010;
        bus.Dout = 32'hDEADBEEF;
        bus.PC   = 32'h00003000;
        bus.DataSrc = 2'b00; settle();
        check("datasrc_00", bus.DataSrcOut, 32'h00000010);
        bus.DataSrc = 2'b01; settle();
        check("datasrc_01", bus.DataSrcOut, 32'hDEADBEEF);
        bus.DataSrc = 2'b10; settle();
        check("datasrc_10", bus.DataSrcOut, 32'h00003004);
        bus.PC = 32'hFFFFFFFC; settle();
        check("link_wrap", bus.DataSrcOut, 32'h00000000);
        bus.PC = 32'h00003000;
        check("selerr_still0", 32'(bus.SelErr), 32'h0);
        bus.DataSrc = 2'b11; settle();
        check("datasrc_11", bus.DataSrcOut, 32'h0);
        edge1();
        check("selerr_set", 32'(bus.SelErr), 32'h1);

        bus.DataSrc = 2'b00;
        for (int i = 0; i < 5; i++) begin
            edge1();
            check("selerr_sticky", 32'(bus.SelErr), 32'h1);
        end
        Reset = 1'b1;
        edge1();
        Reset = 1'b0;
        check("selerr_clr2", 32'(bus.SelErr), 32'h0);

        bus.RegDst = 2'b11;
        Reset = 1'b1;
        edge1();
        check("rst_prio", 32'(bus.SelErr), 32'h0);
        bus.RegDst = 2'b00;
        Reset = 1'b0;
        edge1();
        check("rst_prio_after", 32'(bus.SelErr), 32'h0);

`ifdef SRC_MUX_OUTREG_EN
        bus.RegDst = 2'b00;
        edge1();
        check("lat_before", 32'(bus.RegDstOut), 32'd8);
        bus.RegDst = 2'b01;
        #1;
        check("lat_hold", 32'(bus.RegDstOut), 32'd8);
        edge1();
        check("lat_update", 32'(bus.RegDstOut), 32'd9);
        bus.DataSrc = 2'b01;
        bus.ALUSrc  = 1'b0;
        Reset = 1'b1;
        edge1();
        Reset = 1'b0;
        check("oreg_rst_regdst", 32'(bus.RegDstOut), 32'h0);
        check("oreg_rst_alusrc", bus.ALUSrcOut, 32'h0);
        check("oreg_rst_datasrc", bus.DataSrcOut, 32'h0);
`else
        bus.RegDst = 2'b01;
        bus.DataSrc = 2'b01;
        Reset = 1'b1;
        edge1();
        check("comb_rst_regdst", 32'(bus.RegDstOut), 32'd9);
        check("comb_rst_datasrc", bus.DataSrcOut, 32'hDEADBEEF);
        Reset = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
